// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the load/store unit
package mem_access_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // RISC-V load/store funct3 encodings (stores use the B/H/W/D subset)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Fault codes reported alongside the fault pulse
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - lane extraction and sign/zero extension of load data
module load_extract
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            i_data,
  input  logic [$clog2(XLEN/8)-1:0]  i_offset,
  input  logic [2:0]                 i_funct3,
  output logic [XLEN-1:0]            o_result
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_keep;
  logic            w_sign;

  // Bring the addressed byte lane down to bit 0
  assign w_shifted = i_data >> {i_offset, 3'b000};

  // Pick the kept width and the extension bit; funct3[2] selects zero extension
  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        w_keep = XLEN'(8'hFF);
        w_sign = w_shifted[7];
      end
      2'b01: begin
        w_keep = XLEN'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      2'b10: begin
        w_keep = XLEN'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_keep = '1;
        w_sign = 1'b0;
      end
    endcase
    if (i_funct3[2]) begin
      w_sign = 1'b0;
    end
  end

  assign o_result = (w_shifted & w_keep) | ({XLEN{w_sign}} & ~w_keep);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between core datapath and MIO bus
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                stall,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic                MemRW,
  output logic                CPU_MIO,
  output logic [ADDR_W-1:0]   Addr_out,
  output logic [XLEN-1:0]     Data_out,
  output logic [XLEN/8-1:0]   byte_en,
  input  logic [XLEN-1:0]     Data_in,
  input  logic                MIO_ready
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [OFF_W-1:0]   r_off;
  logic [ADDR_W-1:0]  r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [BE_W-1:0]    r_be;
  logic [XLEN-1:0]    r_rdata;
  logic               r_timeout;

  logic [OFF_W-1:0]   w_off;
  logic               w_legal;
  logic               w_misaligned;
  logic               w_start;
  logic               w_issue;
  logic               w_reject;
  logic [BE_W-1:0]    w_be;
  logic [XLEN-1:0]    w_wdata_sh;
  logic [ADDR_W-1:0]  w_addr_al;
  logic [XLEN-1:0]    w_ext;

  assign w_off     = req_addr[OFF_W-1:0];
  assign w_addr_al = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Doubleword and LWU only exist on a 64-bit datapath; stores have no unsigned forms
  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: w_legal = 1'b1;
      F3_D:             w_legal = (XLEN == 64);
      F3_BU, F3_HU:     w_legal = !req_we;
      F3_WU:            w_legal = !req_we && (XLEN == 64);
      default:          w_legal = 1'b0;
    endcase
  end

  // Natural alignment check by access size
  always_comb begin
    w_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // w_start feeds the sequencer; output copies are also gated by reset so the
  // bus stays quiet while rst is low even if the core presents a request
  assign w_start  = (r_state == IDLE) && req_valid && w_legal && !w_misaligned;
  assign w_issue  = w_start && rst;
  assign w_reject = (r_state == IDLE) && req_valid && !(w_legal && !w_misaligned) && rst;

  // Write lane enables; loads never assert byte_en
  always_comb begin
    w_be = '0;
    case (req_funct3[1:0])
      2'b00:   w_be = BE_W'(1) << w_off;
      2'b01:   w_be = BE_W'(3) << w_off;
      2'b10:   w_be = BE_W'(4'hF) << w_off;
      default: w_be = '1;
    endcase
    if (!req_we) begin
      w_be = '0;
    end
  end

  // Store data moved into its lane; load cycles keep the write bus at zero
  assign w_wdata_sh = req_we ? (req_wdata << {w_off, 3'b000}) : '0;

  load_extract #(
    .XLEN(XLEN)
  ) u_load_extract (
    .i_data   (r_rdata),
    .i_offset (r_off),
    .i_funct3 (r_funct3),
    .o_result (w_ext)
  );

  // Sequencer: latch on issue, count wait cycles, capture read data on ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_off     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= WAIT;
            r_cnt     <= '0;
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_off     <= w_off;
            r_addr    <= w_addr_al;
            r_wdata   <= w_wdata_sh;
            r_be      <= w_be;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
          end
        end
        WAIT: begin
          if (MIO_ready) begin
            if (!r_we) begin
              r_rdata <= Data_in;
            end
            r_state <= RESP;
          end else if (r_cnt == CNT_MAX) begin
            r_timeout <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: issue cycle is combinational from the request, later cycles from the latch
  always_comb begin
    stall      = 1'b0;
    CPU_MIO    = 1'b0;
    MemRW      = 1'b0;
    Addr_out   = '0;
    Data_out   = '0;
    byte_en    = '0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    fault      = 1'b0;
    fault_code = FAULT_NONE;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          stall    = 1'b1;
          CPU_MIO  = 1'b1;
          MemRW    = req_we;
          Addr_out = w_addr_al;
          Data_out = w_wdata_sh;
          byte_en  = w_be;
        end else if (w_reject) begin
          fault      = 1'b1;
          fault_code = FAULT_MISALIGN;
        end
      end
      WAIT: begin
        stall    = 1'b1;
        CPU_MIO  = 1'b1;
        MemRW    = r_we;
        Addr_out = r_addr;
        Data_out = r_wdata;
        byte_en  = r_be;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (r_timeout) begin
          fault      = 1'b1;
          fault_code = FAULT_TIMEOUT;
        end else begin
          rsp_rdata = w_ext;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        fault;
  logic [1:0]  fault_code;
  logic        MemRW;
  logic        CPU_MIO;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [3:0]  byte_en;
  logic [31:0] Data_in;
  logic        MIO_ready;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_data;
    logic        flt;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  mem_access_unit #(
    .XLEN(32),
    .ADDR_W(32),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .fault      (fault),
    .fault_code (fault_code),
    .MemRW      (MemRW),
    .CPU_MIO    (CPU_MIO),
    .Addr_out   (Addr_out),
    .Data_out   (Data_out),
    .byte_en    (byte_en),
    .Data_in    (Data_in),
    .MIO_ready  (MIO_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every retired access must match the oldest pushed expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected rdata=%h fault=%b code=%b", rsp_rdata, fault, fault_code);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.chk_data && rsp_rdata !== mon_e.rdata) || fault !== mon_e.flt || fault_code !== mon_e.code) begin
          errors++;
          $display("FAIL rsp_compare got rdata=%h fault=%b code=%b want rdata=%h fault=%b code=%b",
                   rsp_rdata, fault, fault_code, mon_e.rdata, mon_e.flt, mon_e.code);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic chk, input logic flt, input logic [1:0] code);
    exp_t e;
    e.rdata = rdata;
    e.chk_data = chk;
    e.flt = flt;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Drives one access; MIO_ready pulses on WAIT cycle ready_at (0 = never)
  task automatic bus_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] din, input int ready_at,
                            output int lat, output int stalls);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    Data_in = din; MIO_ready = 1'b0;
    lat = 0; stalls = 0;
    @(negedge clk);
    if (stall === 1'b1) stalls++;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      MIO_ready = (ready_at != 0 && c == ready_at);
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      if (rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    MIO_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h100; req_wdata = 32'h0;
    Data_in = 32'h0; MIO_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, CPU_MIO, MemRW, fault, rsp_valid, byte_en, Addr_out, Data_out, rsp_rdata, fault_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b mio=%b flt=%b rsp=%b be=%h addr=%h want all zero",
               stall, CPU_MIO, fault, rsp_valid, byte_en, Addr_out);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    MIO_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({stall, CPU_MIO, fault, rsp_valid, byte_en, Addr_out} !== '0) begin
        errors++;
        $display("FAIL idle_quiet stall=%b mio=%b flt=%b rsp=%b be=%h addr=%h want all zero",
                 stall, CPU_MIO, fault, rsp_valid, byte_en, Addr_out);
      end
    end
    MIO_ready = 1'b0;
  endtask

  task automatic test_lw();
    int lat, st;
    push_exp(32'hDEADBEEF, 1'b1, 1'b0, FAULT_NONE);
    bus_access(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1, lat, st);
    checks++;
    if (lat !== 2 || st !== 2) begin
      errors++;
      $display("FAIL lw_latency got lat=%0d stall_cycles=%0d want 2 2", lat, st);
    end
  endtask

  task automatic test_sub_word_loads();
    logic [2:0]  f3s   [6];
    logic [31:0] addrs [6];
    logic [31:0] exps  [6];
    int          rdy   [6];
    int lat, st;
    f3s   = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_HU};
    addrs = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
    exps  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000022, 32'h00002233};
    rdy   = '{1, 1, 2, 1, 3, 1};
    for (int i = 0; i < 6; i++) begin
      push_exp(exps[i], 1'b1, 1'b0, FAULT_NONE);
      bus_access(1'b0, f3s[i], addrs[i], 32'h0, 32'h80112233, rdy[i], lat, st);
      checks++;
      if (lat !== rdy[i] + 1 || st !== rdy[i] + 1) begin
        errors++;
        $display("FAIL load_latency case=%0d got lat=%0d stalls=%0d want %0d", i, lat, st, rdy[i] + 1);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s   [4];
    logic [31:0] addrs [4];
    logic [31:0] wds   [4];
    logic [31:0] eaddr [4];
    logic [31:0] edata [4];
    logic [3:0]  ebe   [4];
    f3s   = '{F3_H, F3_B, F3_W, F3_B};
    addrs = '{32'h102, 32'h101, 32'h104, 32'h103};
    wds   = '{32'h0000ABCD, 32'h12345678, 32'hCAFEF00D, 32'h000000A5};
    eaddr = '{32'h100, 32'h100, 32'h104, 32'h100};
    edata = '{32'hABCD0000, 32'h34567800, 32'hCAFEF00D, 32'hA5000000};
    ebe   = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3s[i]; req_addr = addrs[i]; req_wdata = wds[i];
      push_exp(32'h0, 1'b0, 1'b0, FAULT_NONE);
      @(negedge clk);
      checks++;
      if ({MemRW, CPU_MIO, stall, Addr_out, Data_out, byte_en} !== {3'b111, eaddr[i], edata[i], ebe[i]}) begin
        errors++;
        $display("FAIL store_issue case=%0d got we=%b mio=%b stall=%b addr=%h data=%h be=%b want addr=%h data=%h be=%b",
                 i, MemRW, CPU_MIO, stall, Addr_out, Data_out, byte_en, eaddr[i], edata[i], ebe[i]);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0; MIO_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({MemRW, CPU_MIO, stall, Addr_out, Data_out, byte_en} !== {3'b111, eaddr[i], edata[i], ebe[i]}) begin
        errors++;
        $display("FAIL store_hold case=%0d got we=%b mio=%b stall=%b addr=%h data=%h be=%b",
                 i, MemRW, CPU_MIO, stall, Addr_out, Data_out, byte_en);
      end
      @(posedge clk); #1;
      MIO_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, stall, CPU_MIO} !== 3'b100) begin
        errors++;
        $display("FAIL store_resp case=%0d got rsp=%b stall=%b mio=%b want 1 0 0", i, rsp_valid, stall, CPU_MIO);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s   [7];
    logic [31:0] addrs [7];
    logic        wes   [7];
    f3s   = '{F3_W, F3_H, F3_W, F3_D, F3_WU, 3'b111, F3_BU};
    addrs = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h100, 32'h100, 32'h100};
    wes   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = wes[i]; req_funct3 = f3s[i]; req_addr = addrs[i]; req_wdata = 32'h11223344;
      @(negedge clk);
      checks++;
      if ({fault, fault_code, CPU_MIO, stall, byte_en} !== {1'b1, FAULT_MISALIGN, 1'b0, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL misalign_pulse case=%0d got fault=%b code=%b mio=%b stall=%b be=%b want 1 01 0 0 0000",
                 i, fault, fault_code, CPU_MIO, stall, byte_en);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({fault, CPU_MIO, stall} !== 3'b000) begin
        errors++;
        $display("FAIL misalign_after case=%0d got fault=%b mio=%b stall=%b want 0 0 0", i, fault, CPU_MIO, stall);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, st;
    push_exp(32'h0, 1'b1, 1'b1, FAULT_TIMEOUT);
    bus_access(1'b0, F3_W, 32'h200, 32'h0, 32'h12345678, 0, lat, st);
    checks++;
    if (lat !== 6 || st !== 6) begin
      errors++;
      $display("FAIL timeout_latency got lat=%0d stalls=%0d want 6 6", lat, st);
    end
    push_exp(32'h12345678, 1'b1, 1'b0, FAULT_NONE);
    bus_access(1'b0, F3_W, 32'h200, 32'h0, 32'h12345678, 4, lat, st);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL late_ready_latency got lat=%0d want 5", lat);
    end
    push_exp(32'h00005678, 1'b1, 1'b0, FAULT_NONE);
    bus_access(1'b0, F3_HU, 32'h200, 32'h0, 32'h12345678, 5, lat, st);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL ready_at_limit_latency got lat=%0d want 6", lat);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, st;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, CPU_MIO, rsp_valid, fault, byte_en, Addr_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs stall=%b mio=%b rsp=%b flt=%b addr=%h want zero",
               stall, CPU_MIO, rsp_valid, fault, Addr_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall, CPU_MIO, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle stall=%b mio=%b rsp=%b want 0 0 0", stall, CPU_MIO, rsp_valid);
    end
    push_exp(32'h0BADF00D, 1'b1, 1'b0, FAULT_NONE);
    bus_access(1'b0, F3_W, 32'h100, 32'h0, 32'h0BADF00D, 1, lat, st);
    checks++;
    if (lat !== 2 || st !== 2) begin
      errors++;
      $display("FAIL post_reset_lw got lat=%0d stalls=%0d want 2 2", lat, st);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit between the CPU core's datapath and the memory/MIO bus. It replaces the direct word-only `Addr_out`/`Data_out`/`MemRW` connection. It adds sub-word accesses with byte enables, sign/zero extension, multi-cycle waits on `MIO_ready` with a core stall, misalignment detection and a bus timeout.

## Interface
Parameters:
- `XLEN`, 32: data width, 32 or 64.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 255: maximum wait cycles for `MIO_ready`; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents a load or store this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
- `req_addr` in ADDR_W: effective address (ALU result).
- `req_wdata` in XLEN: store data (rs2).
- `stall` out 1: core must hold PC and all state.
- `rsp_valid` out 1: one-cycle pulse; access retired.
- `rsp_rdata` out XLEN: extended load data, valid with `rsp_valid`.
- `fault` out 1: one-cycle pulse, misaligned access or timeout.
- `fault_code` out 2: 01 = misaligned, 10 = timeout, 00 = none.
- `MemRW` out 1: 1 = write.
- `CPU_MIO` out 1: bus request.
- `Addr_out` out ADDR_W: bus address, aligned down to XLEN/8 bytes.
- `Data_out` out XLEN: store data shifted into its lane.
- `byte_en` out XLEN/8: write byte lanes.
- `Data_in` in XLEN: bus read data.
- `MIO_ready` in 1: bus completion.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE, no `req_valid`:** stays in IDLE; all bus outputs 0.
- **IDLE, `req_valid`, misaligned:**
  - Misaligned means: H with `addr[0]`; W with `addr[1:0]`≠0; D with `addr[2:0]`≠0.
  - Pulses `fault`, `fault_code`=01.
  - `stall`=0, no bus cycle, stays in IDLE.
- **IDLE, `req_valid`, illegal funct3:** D or LWU with XLEN=32, or an undefined encoding. Treated as misaligned.
- **IDLE, `req_valid`, legal and aligned:**
  - Latches the request.
  - Drives `CPU_MIO`=1, `MemRW`=`req_we`, `Addr_out`, `Data_out`, `byte_en` combinationally in the same cycle.
  - `stall`=1; next state WAIT; wait counter cleared.
- **WAIT:**
  - Bus outputs are held from the latched copy; `stall`=1.
  - On `MIO_ready`: loads capture `Data_in` into a register; next state RESP.
  - If the counter reaches TIMEOUT without `MIO_ready`: next state RESP with the timeout flag set.
- **RESP:**
  - `rsp_valid`=1, `stall`=0, `CPU_MIO`=0.
  - `rsp_rdata` is the extracted lane. On timeout, `rsp_rdata`=0 and `fault`=1 with `fault_code`=10.
  - `req_valid` is ignored in this cycle (it is the same instruction). Always returns to IDLE.
- **Byte enables**, with off = `addr[log2(XLEN/8)-1:0]`:
  - B → `1<<off`, H → `3<<off`, W → `4'hF<<off`, D → all ones.
  - Loads drive `byte_en`=0.
  - `Data_out` = `req_wdata << (8*off)`, truncated to XLEN.
- **Load extraction:** shift `Data_in` right by `8*off`, then sign- or zero-extend at 8/16/32 bits according to funct3[2].
- **Simultaneous events:** `MIO_ready` in the same cycle the counter hits TIMEOUT counts as success. `MIO_ready` outside WAIT is ignored.
- **Reset:** asynchronous assertion mid-access forces IDLE and clears all outputs and latched state; the bus cycle is abandoned.

## Timing
- All outputs are 0 in reset and in IDLE without a request.
- Minimum load/store latency is 2 cycles:
  - cycle 0: IDLE issue, `stall`=1;
  - cycle 1: WAIT with `MIO_ready`;
  - cycle 2: RESP, `rsp_valid`.
- Each extra cycle of `MIO_ready` low adds one cycle.
- A timeout retires at TIMEOUT+2 cycles after issue.
- `stall` is combinational from `req_valid` in IDLE; registered state otherwise.
- `rsp_rdata` comes from a registered capture, so there is no combinational `Data_in`→core path.
- Wait counter width is `$clog2(TIMEOUT+1)` and saturates; it never wraps.

## Structure
- Package `mem_access_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`);
  - fault code constants.
- Sub-module `load_extract`, combinational, parameters XLEN: inputs data, offset, funct3; output extended result.
- Byte enable and store shift logic stay inline.

## Test plan
1. LW at 0x100, `Data_in`=0xDEADBEEF, `MIO_ready` on the first WAIT cycle → `stall` high 2 cycles, `rsp_rdata`=0xDEADBEEF at cycle 2.
2. LB at 0x103 and LBU at 0x103, `Data_in`=0x80112233 → `rsp_rdata`=0xFFFFFF80, then 0x00000080.
3. SH at 0x102, `req_wdata`=0x0000ABCD → `byte_en`=4'b1100, `Data_out`=0xABCD0000, `MemRW`=1, `Addr_out`=0x100.
4. LW at 0x101 → `fault` pulse, `fault_code`=01, `CPU_MIO` never asserts, `stall`=0.
5. TIMEOUT=4 with `MIO_ready` held low → `rsp_valid` and `fault` (code 10) exactly 6 cycles after issue, `rsp_rdata`=0; with `MIO_ready` rising on the 4th WAIT cycle instead → normal completion, no fault.
6. `rst` driven low during WAIT → outputs 0 immediately, IDLE after release; a new LW completes normally.
